// File: rtl/amo_pkg.sv
// Shared types for the RV64A atomic sequencer and the AMO ALU it drives.
package amo_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SWAP = 2'd1,
        OP_LR   = 2'd2,
        OP_SC   = 2'd3
    } amo_op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        ALU_ISSUE,
        ALU_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } amo_state_e;

    localparam logic [2:0] ALU_FUNCT_ADD  = 3'd0;
    localparam logic [2:0] ALU_FUNCT_SWAP = 3'd1;

    // The ALU funct field is the zero-extended op code.
    function automatic logic [2:0] aluFunct(input amo_op_e op);
        case (op)
            OP_ADD:  return ALU_FUNCT_ADD;
            OP_SWAP: return ALU_FUNCT_SWAP;
            default: return {1'b0, op};
        endcase
    endfunction

endpackage

// File: rtl/amo_resv.sv
// LR/SC reservation register: one doubleword-granular address plus a snoop
// compare that kills the reservation (or a same-cycle set) on a matching invalidate.
module amo_resv #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic              clear_i,
    input  logic [ADDR_W-4:0] setAddr_i,
    input  logic [ADDR_W-4:0] lookupAddr_i,
    input  logic              inv_valid_i,
    input  logic [ADDR_W-4:0] invAddr_i,
    output logic              hit_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-4:0] addr_q, addr_d;
    logic              invHitsResv;
    logic              invHitsSet;

    assign invHitsResv = inv_valid_i && valid_q && (invAddr_i == addr_q);
    assign invHitsSet  = inv_valid_i && (invAddr_i == setAddr_i);
    assign hit_o       = valid_q && (lookupAddr_i == addr_q) && !invHitsResv;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (set_i) begin
            valid_d = !invHitsSet;
            addr_d  = setAddr_i;
        end else if (clear_i || invHitsResv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/amo_seq.sv
// RV64A atomic sequencer: runs AMOADD/AMOSWAP/LR/SC against the data-cache port,
// drives the AMO ALU for the modify step and owns the LR/SC reservation.
module amo_seq
    import amo_pkg::*;
#(
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [63:0]       req_data_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [63:0]       mem_req_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [63:0]       mem_rsp_rdata_i,
    output logic              alu_valid_o,
    output logic [63:0]       alu_op_a_o,
    output logic [63:0]       alu_op_b_o,
    output logic [2:0]        alu_funct_o,
    input  logic              alu_ready_i,
    input  logic [63:0]       alu_result_i,
    input  logic              inv_valid_i,
    input  logic [ADDR_W-1:0] inv_addr_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [63:0]       wb_data_o,
    output logic              wb_exc_o
);

    amo_state_e        state_q, state_d;
    amo_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [63:0]       result_q, result_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              exc_q, exc_d;
    logic              resvSet, resvClear, resvHit;
    logic [ADDR_W-4:0] lookupAddr;
    logic              unusedInvBits;

    assign unusedInvBits = ^inv_addr_i[2:0];

    // SC checks the incoming address at accept; later AMO writes check the latched one.
    assign lookupAddr = (state_q == IDLE) ? req_addr_i[ADDR_W-1:3] : addr_q[ADDR_W-1:3];

    amo_resv #(.ADDR_W(ADDR_W)) u_resv (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_i        (resvSet),
        .clear_i      (resvClear),
        .setAddr_i    (addr_q[ADDR_W-1:3]),
        .lookupAddr_i (lookupAddr),
        .inv_valid_i  (inv_valid_i),
        .invAddr_i    (inv_addr_i[ADDR_W-1:3]),
        .hit_o        (resvHit)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tag_d     = tag_q;
        result_d  = result_q;
        wdata_d   = wdata_q;
        exc_d     = exc_q;
        resvSet   = 1'b0;
        resvClear = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = amo_op_e'(req_op_i);
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    wdata_d = req_data_i;
                    tag_d   = req_tag_i;
                    exc_d   = 1'b0;
                    if (req_addr_i[2:0] != 3'd0) begin
                        exc_d     = 1'b1;
                        result_d  = '0;
                        resvClear = 1'b1;
                        state_d   = RESP;
                    end else if (amo_op_e'(req_op_i) == OP_SC) begin
                        resvClear = 1'b1;
                        if (resvHit) begin
                            result_d = 64'd0;
                            state_d  = WR_REQ;
                        end else begin
                            result_d = 64'd1;
                            state_d  = RESP;
                        end
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: if (mem_req_ready_i) state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_rsp_valid_i) begin
                    result_d = mem_rsp_rdata_i;
                    if (op_q == OP_LR) begin
                        resvSet = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ALU_ISSUE;
                    end
                end
            end
            ALU_ISSUE: state_d = ALU_WAIT;
            ALU_WAIT: begin
                if (alu_ready_i) begin
                    wdata_d = alu_result_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_req_ready_i) begin
                    resvClear = (op_q != OP_SC) && resvHit;
                    state_d   = WR_WAIT;
                end
            end
            WR_WAIT: if (mem_rsp_valid_i) state_d = RESP;
            RESP: if (wb_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            exc_q    <= exc_d;
        end
    end

    assign req_ready_o     = (state_q == IDLE);
    assign mem_req_valid_o = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_req_we_o    = (state_q == WR_REQ);
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;
    assign alu_valid_o     = (state_q == ALU_ISSUE);
    assign alu_op_a_o      = result_q;
    assign alu_op_b_o      = data_q;
    assign alu_funct_o     = aluFunct(op_q);
    assign wb_valid_o      = (state_q == RESP);
    assign wb_tag_o        = tag_q;
    assign wb_data_o       = result_q;
    assign wb_exc_o        = exc_q;

endmodule
